// File: rtl/regfile_port_arb.sv
// Register-file port arbiter: shares the write port and read port 2 between the core and a debug port.
// Optional starvation stall on blocked debug writes is built only when REGFILE_ARB_STARVE_EN is defined.
module regfile_port_arb #(
  parameter int p_WORD_LEN     = 16,
  parameter int p_REG_ADDR_LEN = 3,
  parameter int p_STARVE_LIMIT = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [p_REG_ADDR_LEN-1:0] i_core_src2,
  input  logic                      i_core_wr_en,
  input  logic [p_REG_ADDR_LEN-1:0] i_core_tgt,
  input  logic [p_WORD_LEN-1:0]     i_core_data,
  output logic                      o_core_stall,
  output logic [p_REG_ADDR_LEN-1:0] o_rf_src2,
  input  logic [p_WORD_LEN-1:0]     i_rf_src2_data,
  output logic                      o_rf_wr_en,
  output logic [p_REG_ADDR_LEN-1:0] o_rf_tgt,
  output logic [p_WORD_LEN-1:0]     o_rf_tgt_data,
  input  logic                      i_dbg_valid,
  output logic                      o_dbg_ready,
  input  logic                      i_dbg_we,
  input  logic [p_REG_ADDR_LEN-1:0] i_dbg_addr,
  input  logic [p_WORD_LEN-1:0]     i_dbg_wdata,
  output logic                      o_dbg_rvalid,
  output logic [p_WORD_LEN-1:0]     o_dbg_rdata,
  output logic [1:0]                o_dbg_state
);

  // Debug handshake: a request transfers on a cycle where i_dbg_valid && o_dbg_ready;
  // the requester holds valid and payload stable until then, and completion is the
  // single-cycle o_dbg_rvalid pulse that follows.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PEND  = 2'd1,
    S_FORCE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic                      we_q, we_d;
  logic [p_REG_ADDR_LEN-1:0] addr_q, addr_d;
  logic [p_WORD_LEN-1:0]     wdata_q, wdata_d;
  logic [p_WORD_LEN-1:0]     rdata_q, rdata_d;
  logic                      starve_hit;

  if (p_STARVE_LIMIT < 1) begin : g_bad_limit
    $error("p_STARVE_LIMIT must be >= 1");
  end

`ifdef REGFILE_ARB_STARVE_EN
  localparam int CNT_W = (p_STARVE_LIMIT < 2) ? 1 : $clog2(p_STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_DONE) begin
      cnt_d = '0;
    end else if (state_q == S_PEND && i_core_wr_en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starve_hit = (cnt_q == CNT_W'(p_STARVE_LIMIT - 1));
`else
  assign starve_hit = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (i_dbg_valid) begin
          we_d    = i_dbg_we;
          addr_d  = i_dbg_addr;
          wdata_d = i_dbg_wdata;
          state_d = i_dbg_we ? S_PEND : S_FORCE;
        end
      end
      S_PEND: begin
        if (!i_core_wr_en) begin
          state_d = S_DONE;
        end else if (starve_hit) begin
          state_d = S_FORCE;
        end
      end
      S_FORCE: begin
        if (!we_q) begin
          rdata_d = i_rf_src2_data;
        end
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The core is frozen in FORCE, so its held writeback is suppressed rather than lost.
  always_comb begin
    o_dbg_ready   = (state_q == S_IDLE);
    o_core_stall  = (state_q == S_FORCE);
    o_dbg_rvalid  = (state_q == S_DONE);
    o_dbg_rdata   = rdata_q;
    o_dbg_state   = state_q;
    o_rf_src2     = i_core_src2;
    o_rf_wr_en    = i_core_wr_en;
    o_rf_tgt      = i_core_tgt;
    o_rf_tgt_data = i_core_data;
    if (state_q == S_FORCE) begin
      if (we_q) begin
        o_rf_wr_en    = 1'b1;
        o_rf_tgt      = addr_q;
        o_rf_tgt_data = wdata_q;
      end else begin
        o_rf_src2  = addr_q;
        o_rf_wr_en = 1'b0;
      end
    end else if (state_q == S_PEND && !i_core_wr_en) begin
      o_rf_wr_en    = 1'b1;
      o_rf_tgt      = addr_q;
      o_rf_tgt_data = wdata_q;
    end
  end

endmodule

// File: tb/tb_regfile_port_arb.sv
// Bench for regfile_port_arb: table-driven passthrough vectors plus directed debug-port sequences
// against a small behavioural register file (r0 reads as zero, ignores writes).
module tb_regfile_port_arb;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [2:0]  i_core_src2;
  logic        i_core_wr_en;
  logic [2:0]  i_core_tgt;
  logic [15:0] i_core_data;
  logic        o_core_stall;
  logic [2:0]  o_rf_src2;
  logic [15:0] i_rf_src2_data;
  logic        o_rf_wr_en;
  logic [2:0]  o_rf_tgt;
  logic [15:0] o_rf_tgt_data;
  logic        i_dbg_valid;
  logic        o_dbg_ready;
  logic        i_dbg_we;
  logic [2:0]  i_dbg_addr;
  logic [15:0] i_dbg_wdata;
  logic        o_dbg_rvalid;
  logic [15:0] o_dbg_rdata;
  logic [1:0]  o_dbg_state;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [15:0] rf [8];

  regfile_port_arb dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_core_src2(i_core_src2), .i_core_wr_en(i_core_wr_en),
    .i_core_tgt(i_core_tgt), .i_core_data(i_core_data),
    .o_core_stall(o_core_stall), .o_rf_src2(o_rf_src2),
    .i_rf_src2_data(i_rf_src2_data), .o_rf_wr_en(o_rf_wr_en),
    .o_rf_tgt(o_rf_tgt), .o_rf_tgt_data(o_rf_tgt_data),
    .i_dbg_valid(i_dbg_valid), .o_dbg_ready(o_dbg_ready),
    .i_dbg_we(i_dbg_we), .i_dbg_addr(i_dbg_addr), .i_dbg_wdata(i_dbg_wdata),
    .o_dbg_rvalid(o_dbg_rvalid), .o_dbg_rdata(o_dbg_rdata),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  // behavioural mem_reg
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 8; i++) rf[i] <= 16'h0000;
    end else if (o_rf_wr_en && o_rf_tgt != 3'd0) begin
      rf[o_rf_tgt] <= o_rf_tgt_data;
    end
  end

  always_comb begin
    i_rf_src2_data = 16'h0000;
    if (o_rf_src2 != 3'd0) i_rf_src2_data = rf[o_rf_src2];
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic dbg_req(input logic we, input logic [2:0] addr, input logic [15:0] wdata);
    i_dbg_valid = 1'b1;
    i_dbg_we    = we;
    i_dbg_addr  = addr;
    i_dbg_wdata = wdata;
  endtask

  typedef struct {
    logic [2:0]  src2;
    logic        wr_en;
    logic [2:0]  tgt;
    logic [15:0] data;
    logic [2:0]  exp_src2;
    logic        exp_wr_en;
    logic [2:0]  exp_tgt;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs [4];

  initial begin
    vecs[0] = '{3'd1, 1'b0, 3'd2, 16'h0001, 3'd1, 1'b0, 3'd2, 16'h0001};
    vecs[1] = '{3'd7, 1'b1, 3'd6, 16'hA5A5, 3'd7, 1'b1, 3'd6, 16'hA5A5};
    vecs[2] = '{3'd0, 1'b1, 3'd7, 16'hFFFF, 3'd0, 1'b1, 3'd7, 16'hFFFF};
    vecs[3] = '{3'd4, 1'b0, 3'd0, 16'h8000, 3'd4, 1'b0, 3'd0, 16'h8000};

    i_rst_n      = 1'b0;
    i_core_src2  = 3'd0;
    i_core_wr_en = 1'b0;
    i_core_tgt   = 3'd0;
    i_core_data  = 16'h0000;
    i_dbg_valid  = 1'b0;
    i_dbg_we     = 1'b0;
    i_dbg_addr   = 3'd0;
    i_dbg_wdata  = 16'h0000;
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset_ready",  o_dbg_ready,  1);
    chk("reset_stall",  o_core_stall, 0);
    chk("reset_rvalid", o_dbg_rvalid, 0);
    chk("reset_rdata",  o_dbg_rdata,  16'h0000);
    i_rst_n = 1'b1;
    tick();

    // default muxing: core owns both ports while idle
    for (int i = 0; i < 4; i++) begin
      i_core_src2  = vecs[i].src2;
      i_core_wr_en = vecs[i].wr_en;
      i_core_tgt   = vecs[i].tgt;
      i_core_data  = vecs[i].data;
      #1;
      chk("pass_src2",  o_rf_src2,     vecs[i].exp_src2);
      chk("pass_wr_en", o_rf_wr_en,    vecs[i].exp_wr_en);
      chk("pass_tgt",   o_rf_tgt,      vecs[i].exp_tgt);
      chk("pass_data",  o_rf_tgt_data, vecs[i].exp_data);
      chk("pass_stall", o_core_stall,  0);
      tick();
    end
    i_core_wr_en = 1'b0;
    i_core_src2  = 3'd6;

    // debug write r3=0xBEEF with idle core
    dbg_req(1'b1, 3'd3, 16'hBEEF);
    #1;
    chk("wr_accept_ready", o_dbg_ready, 1);
    tick();
    i_dbg_valid = 1'b0;
    #1;
    chk("wr_t1_wr_en", o_rf_wr_en, 1);
    chk("wr_t1_tgt",   o_rf_tgt, 3);
    chk("wr_t1_data",  o_rf_tgt_data, 16'hBEEF);
    chk("wr_t1_stall", o_core_stall, 0);
    chk("wr_t1_rvalid", o_dbg_rvalid, 0);
    tick();
    chk("wr_t2_rvalid", o_dbg_rvalid, 1);
    chk("wr_t2_ready",  o_dbg_ready, 0);
    tick();
    chk("wr_t3_rvalid", o_dbg_rvalid, 0);
    chk("wr_t3_ready",  o_dbg_ready, 1);
    chk("wr_r3_model",  rf[3], 16'hBEEF);

    // debug read r3 with a core write to r3 held during the stall
    dbg_req(1'b0, 3'd3, 16'h0000);
    tick();
    dbg_req(1'b1, 3'd7, 16'h7777);
    i_core_wr_en = 1'b1;
    i_core_tgt   = 3'd3;
    i_core_data  = 16'h5555;
    #1;
    chk("rd_t1_stall", o_core_stall, 1);
    chk("rd_t1_src2",  o_rf_src2, 3);
    chk("rd_t1_wr_en", o_rf_wr_en, 0);
    chk("rd_t1_ready", o_dbg_ready, 0);
    tick();
    i_dbg_valid = 1'b0;
    #1;
    chk("rd_t2_rvalid", o_dbg_rvalid, 1);
    chk("rd_t2_rdata",  o_dbg_rdata, 16'hBEEF);
    chk("rd_t2_stall",  o_core_stall, 0);
    chk("rd_t2_core_wr", o_rf_wr_en, 1);
    tick();
    i_core_wr_en = 1'b0;
    #1;
    chk("rd_t3_rvalid", o_dbg_rvalid, 0);
    chk("rd_t3_hold",   o_dbg_rdata, 16'hBEEF);
    chk("rd_core_r3",   rf[3], 16'h5555);
    chk("rd_ignored_r7", rf[7] == 16'h7777, 0);

    // blocked debug write r5=0x1234 while the core writes r1 every cycle
    i_core_wr_en = 1'b1;
    i_core_tgt   = 3'd1;
    i_core_data  = 16'h0A00;
    dbg_req(1'b1, 3'd5, 16'h1234);
    tick();
    i_dbg_valid = 1'b0;
`ifdef REGFILE_ARB_STARVE_EN
    for (int i = 0; i < 4; i++) begin
      i_core_data = 16'h0A01 + 16'(i);
      #1;
      chk("st_pend_stall",  o_core_stall, 0);
      chk("st_pend_tgt",    o_rf_tgt, 1);
      chk("st_pend_data",   o_rf_tgt_data, 16'h0A01 + 16'(i));
      chk("st_pend_rvalid", o_dbg_rvalid, 0);
      tick();
    end
    chk("st_force_stall", o_core_stall, 1);
    chk("st_force_wr_en", o_rf_wr_en, 1);
    chk("st_force_tgt",   o_rf_tgt, 5);
    chk("st_force_data",  o_rf_tgt_data, 16'h1234);
    tick();
    chk("st_done_rvalid", o_dbg_rvalid, 1);
    chk("st_done_stall",  o_core_stall, 0);
    i_core_wr_en = 1'b0;
    tick();
`else
    for (int i = 0; i < 6; i++) begin
      i_core_data = 16'h0A01 + 16'(i);
      #1;
      chk("bl_pend_stall",  o_core_stall, 0);
      chk("bl_pend_tgt",    o_rf_tgt, 1);
      chk("bl_pend_rvalid", o_dbg_rvalid, 0);
      tick();
    end
    i_core_wr_en = 1'b0;
    #1;
    chk("bl_gap_wr_en", o_rf_wr_en, 1);
    chk("bl_gap_tgt",   o_rf_tgt, 5);
    chk("bl_gap_data",  o_rf_tgt_data, 16'h1234);
    chk("bl_gap_stall", o_core_stall, 0);
    tick();
    chk("bl_done_rvalid", o_dbg_rvalid, 1);
    tick();
`endif
    chk("blk_r5_model", rf[5], 16'h1234);
    chk("blk_idle_ready", o_dbg_ready, 1);

    // r0: write is issued but discarded, read returns zero
    dbg_req(1'b1, 3'd0, 16'hFFFF);
    tick();
    i_dbg_valid = 1'b0;
    #1;
    chk("r0_wr_issue", o_rf_wr_en, 1);
    chk("r0_wr_tgt",   o_rf_tgt, 0);
    tick();
    chk("r0_wr_rvalid", o_dbg_rvalid, 1);
    tick();
    dbg_req(1'b0, 3'd0, 16'h0000);
    tick();
    i_dbg_valid = 1'b0;
    #1;
    chk("r0_rd_src2", o_rf_src2, 0);
    tick();
    chk("r0_rd_rvalid", o_dbg_rvalid, 1);
    chk("r0_rd_rdata",  o_dbg_rdata, 16'h0000);
    tick();

    // asynchronous reset while in the forced stall
    dbg_req(1'b0, 3'd3, 16'h0000);
    tick();
    i_dbg_valid = 1'b0;
    #1;
    chk("rst_pre_stall", o_core_stall, 1);
    i_rst_n = 1'b0;
    #1;
    chk("rst_stall",  o_core_stall, 0);
    chk("rst_rvalid", o_dbg_rvalid, 0);
    chk("rst_ready",  o_dbg_ready, 1);
    tick();
    i_rst_n = 1'b1;
    tick();
    chk("rst_rel_ready",  o_dbg_ready, 1);
    chk("rst_rel_rvalid", o_dbg_rvalid, 0);
    chk("rst_rel_rdata",  o_dbg_rdata, 16'h0000);
    tick();
    chk("rst_no_rvalid", o_dbg_rvalid, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
